disaggregator: RTL and testbench



---
 rtl/disaggregator_pkg.sv | 32 +++
 rtl/disaggregator_if.sv | 38 +++
 rtl/disaggregator.sv | 124 ++++++++++++
 tb/tb_disaggregator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disaggregator_pkg.sv
// -----------------------------------------------------------------------------
// disaggregator_pkg
//   Shared definitions for the wide-to-narrow disaggregator and its aggregator
//   counterpart: default widths, slice-count width helper, FSM state encoding
//   and the slice-count clamp used when a new width is programmed.
//   No ports (package).
//   Related build option: DISAGG_PREFETCH_EN (used by disaggregator.sv).
// -----------------------------------------------------------------------------
package disaggregator_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int FETCH_WIDTH_DEF = 40;

  // Bits needed to hold a slice count in 0..fetch_width.
  function automatic int cw_of(input int fetch_width);
    return $clog2(fetch_width + 1);
  endfunction

  localparam int CW_DEF = cw_of(FETCH_WIDTH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // A zero or oversized slice count falls back to the full word.
  function automatic int unsigned clamp_width(input int unsigned w,
                                              input int unsigned max_w);
    return ((w == 0) || (w > max_w)) ? max_w : w;
  endfunction

endpackage

// File: rtl/disaggregator_if.sv
// -----------------------------------------------------------------------------
// disaggregator_if
//   Stream-side signals of the disaggregator: upstream (wide) FIFO read port
//   and downstream (narrow) FIFO write port.
//   Signals:
//     sender_data     wide word, slice i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//     sender_empty_n  upstream FIFO not empty
//     sender_deq      dequeue strobe to upstream FIFO
//     receiver_data   output slice
//     receiver_full_n downstream FIFO not full
//     receiver_enq    enqueue strobe qualifying receiver_data
//   Modports: master = disaggregator side, slave = FIFO/environment side.
// -----------------------------------------------------------------------------
interface disaggregator_if
  import disaggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF
) ();

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;

  modport master (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq
  );

  modport slave (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq
  );

endinterface

// File: rtl/disaggregator.sv
// -----------------------------------------------------------------------------
// disaggregator
//   Dequeues one FETCH_WIDTH*DATA_WIDTH-bit word from an upstream FIFO and
//   emits its first len_q DATA_WIDTH slices, slice 0 first, one per cycle into
//   a downstream FIFO. The slice count is programmable at run time and only
//   takes effect on the next word loaded.
//   Ports:
//     clk                 single clock
//     rst                 synchronous active-high reset
//     bus                 disaggregator_if.master (sender/receiver handshakes)
//     change_fetch_width  one-cycle strobe loading input_fetch_width
//     input_fetch_width   new slice count (0 or > FETCH_WIDTH means FETCH_WIDTH)
//   Build option:
//     DISAGG_PREFETCH_EN  when defined, the next word is dequeued on the edge
//                         that emits the last slice, removing the IDLE bubble.
// -----------------------------------------------------------------------------
module disaggregator
  import disaggregator_pkg::*;
#(
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int FETCH_WIDTH = FETCH_WIDTH_DEF,
  localparam int CW          = cw_of(FETCH_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  disaggregator_if.master        bus,
  input  logic                   change_fetch_width,
  input  logic [CW-1:0]          input_fetch_width
);

  state_e                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         pend_q, pend_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  enq_q, enq_d;
  logic [DATA_WIDTH-1:0] slice_buf_q [FETCH_WIDTH];
  logic                  load;
  logic                  last_slice;

  assign last_slice = (idx_q == len_q - CW'(1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned; otherwise synthesis would infer latches.
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pend_d  = pend_q;
    data_d  = data_q;
    enq_d   = 1'b0;
    load    = 1'b0;

    if (change_fetch_width) begin
      pend_d = CW'(clamp_width(32'(input_fetch_width), FETCH_WIDTH));
    end

    case (state_q)
      IDLE: begin
        load = !rst && bus.sender_empty_n;
      end
      SEND: begin
        if (bus.receiver_full_n) begin
          data_d = slice_buf_q[idx_q];
          enq_d  = 1'b1;
          if (last_slice) begin
            idx_d   = '0;
            state_d = IDLE;
`ifdef DISAGG_PREFETCH_EN
            // Chain straight into the next word while the last slice leaves.
            load = !rst && bus.sender_empty_n;
`endif
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load always starts a fresh word using the width programmed before
    // this edge; a coincident width change lands in pend_d for the next one.
    if (load) begin
      len_d   = pend_q;
      idx_d   = '0;
      state_d = SEND;
    end
  end

  assign bus.sender_deq    = load;
  assign bus.receiver_data = data_q;
  assign bus.receiver_enq  = enq_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= CW'(FETCH_WIDTH);
      pend_q  <= CW'(FETCH_WIDTH);
      data_q  <= '0;
      enq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      enq_q   <= enq_d;
    end
  end

  // NOTE: the slice buffer is deliberately not reset; it is always written by
  // a load before any slice of it is read, so reset would only cost routing.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        slice_buf_q[i] <= bus.sender_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// -----------------------------------------------------------------------------
// tb_disaggregator
//   Self-checking bench for disaggregator. An upstream FIFO and a slice
//   scoreboard live in the bench: each dequeued word expands into the slices
//   the current programmed width allows, and every enqueue must match the
//   head of that list. Directed scenarios cover reset, latency, back-pressure,
//   width changes, back-to-back words, reset mid-word and an empty upstream;
//   a randomized phase follows. Honors DISAGG_PREFETCH_EN for timing checks.
// -----------------------------------------------------------------------------
module tb_disaggregator;
  import disaggregator_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int FW = FETCH_WIDTH_DEF;
  localparam int CW = cw_of(FW);

  typedef logic [FW*DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          change_fetch_width;
  logic [CW-1:0] input_fetch_width;

  disaggregator_if bus_if ();

  disaggregator dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus_if),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width)
  );

  always #5 clk = ~clk;

  word_t          up_q[$];
  logic [DW-1:0]  exp_q[$];
  int             model_pend;
  int             cyc;
  int             enq_cnt;
  int             deq_cnt;
  int             first_enq;
  int             last_enq;
  logic           s_deq;
  logic           s_enq;
  logic [DW-1:0]  s_data;
  logic           prev_stall;
  logic [DW-1:0]  prev_data;
  int             n_pass;
  int             n_checks;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int model_clamp(input int w);
    return (w < 1 || w > FW) ? FW : w;
  endfunction

  task automatic refresh();
    bus_if.sender_empty_n = (up_q.size() != 0);
    bus_if.sender_data    = (up_q.size() != 0) ? up_q[0] : '0;
  endtask

  task automatic push_word(input word_t w);
    up_q.push_back(w);
    refresh();
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < FW * DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic mark();
    enq_cnt   = 0;
    deq_cnt   = 0;
    first_enq = -1;
    last_enq  = -1;
  endtask

  // One clock: sample outputs at the falling edge, update the model, then
  // let the rising edge pass and retire the dequeued word.
  task automatic tick();
    bit    pop;
    word_t w;
    pop = 1'b0;
    @(negedge clk);
    cyc++;
    s_deq  = bus_if.sender_deq;
    s_enq  = bus_if.receiver_enq;
    s_data = bus_if.receiver_data;

    if (prev_stall) begin
      check("stall_enq", 32'(s_enq), 32'(0));
      check("stall_data", 32'(s_data), 32'(prev_data));
    end

    if (s_enq) begin
      enq_cnt++;
      if (first_enq < 0) first_enq = cyc;
      last_enq = cyc;
      if (exp_q.size() == 0) check("spurious_enq", 32'(s_enq), 32'(0));
      else                   check("slice", 32'(s_data), 32'(exp_q.pop_front()));
    end

    if (s_deq) begin
      deq_cnt++;
      if (up_q.size() == 0 || rst) begin
        check("bad_deq", 32'(s_deq), 32'(0));
      end else begin
        w = up_q[0];
        for (int i = 0; i < model_pend; i++) exp_q.push_back(w[i*DW +: DW]);
        pop = 1'b1;
      end
    end

    if (rst) begin
      exp_q.delete();
      model_pend = FW;
    end else if (change_fetch_width) begin
      model_pend = model_clamp(int'(input_fetch_width));
    end

    prev_stall = !rst && !bus_if.receiver_full_n;
    prev_data  = s_data;

    @(posedge clk);
    #1;
    if (pop) void'(up_q.pop_front());
    refresh();
  endtask

  task automatic set_width(input int v);
    change_fetch_width = 1'b1;
    input_fetch_width  = CW'(v);
    tick();
    change_fetch_width = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0) && k < limit) begin
      tick();
      k++;
    end
    if (up_q.size() != 0 || exp_q.size() != 0)
      check("drain_timeout", 32'(up_q.size() + exp_q.size()), 32'(0));
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    word_t w;
    logic  pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int    c0;

    n_pass = 0; n_checks = 0; cyc = 0;
    model_pend = FW;
    prev_stall = 1'b0;
    prev_data  = '0;
    rst = 1'b1;
    change_fetch_width = 1'b0;
    input_fetch_width  = '0;
    bus_if.receiver_full_n = 1'b1;
    refresh();
    mark();

    // Reset state; a queued word must not be dequeued while in reset.
    for (int i = 0; i < FW; i++) w[i*DW +: DW] = DW'(16'h0100 + i);
    push_word(w);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("deq_in_rst", 32'(s_deq), 32'(0));
    end
    check("rst_enq", 32'(s_enq), 32'(0));
    check("rst_data", 32'(s_data), 32'(0));

    // Basic word at default width 40.
    rst = 1'b0;
    mark();
    tick();
    check("basic_deq", 32'(s_deq), 32'(1));
    c0 = cyc;
    drain(200);
    check("basic_latency", 32'(first_enq - c0), 32'(2));
    check("basic_count", 32'(enq_cnt), 32'(40));
    check("basic_contig", 32'(last_enq - first_enq), 32'(39));
    check("basic_deq_count", 32'(deq_cnt), 32'(1));
    check("basic_idle_enq", 32'(s_enq), 32'(0));

    // Back-pressure at width 4; upper slices carry garbage that must not leak.
    set_width(4);
    w = rand_word();
    for (int i = 0; i < 4; i++) w[i*DW +: DW] = DW'(i + 1);
    mark();
    push_word(w);
    tick();
    for (int i = 0; i < 7; i++) begin
      bus_if.receiver_full_n = pat[i];
      tick();
    end
    bus_if.receiver_full_n = 1'b1;
    drain(100);
    check("bp_count", 32'(enq_cnt), 32'(4));

    // Width change while a word is in flight.
    set_width(8);
    mark();
    push_word(rand_word());
    push_word(rand_word());
    for (int k = 0; k < 100 && enq_cnt < 5; k++) tick();
    check("wchg_reach", 32'(enq_cnt), 32'(5));
    change_fetch_width = 1'b1;
    input_fetch_width  = CW'(3);
    tick();
    change_fetch_width = 1'b0;
    drain(200);
    check("wchg_count", 32'(enq_cnt), 32'(11));

    // Programmed width 0 means full word.
    set_width(0);
    mark();
    push_word(rand_word());
    drain(200);
    check("w0_count", 32'(enq_cnt), 32'(40));

    // Three queued words back to back at width 5.
    set_width(5);
    mark();
    for (int i = 0; i < 3; i++) push_word(rand_word());
    drain(200);
    check("b2b_count", 32'(enq_cnt), 32'(15));
`ifdef DISAGG_PREFETCH_EN
    check("b2b_span", 32'(last_enq - first_enq), 32'(14));
`else
    check("b2b_span", 32'(last_enq - first_enq), 32'(16));
`endif

    // Reset in the middle of a 6-slice word.
    set_width(6);
    mark();
    push_word(rand_word());
    for (int k = 0; k < 100 && enq_cnt < 2; k++) tick();
    check("rmid_reach", 32'(enq_cnt), 32'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mark();
    push_word(rand_word());
    tick();
    check("rmid_enq", 32'(s_enq), 32'(0));
    check("rmid_idle_deq", 32'(s_deq), 32'(1));
    drain(200);
    check("rmid_count", 32'(enq_cnt), 32'(40));

    // Empty upstream: nothing moves.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("empty_deq", 32'(s_deq), 32'(0));
      check("empty_enq", 32'(s_enq), 32'(0));
    end

    // Randomized traffic: random back-pressure, widths and word arrivals.
    for (int i = 0; i < 1500; i++) begin
      bus_if.receiver_full_n = ($urandom_range(3) != 0);
      if ($urandom_range(39) == 0) begin
        change_fetch_width = 1'b1;
        input_fetch_width  = CW'($urandom_range((1 << CW) - 1));
      end else begin
        change_fetch_width = 1'b0;
      end
      if (up_q.size() < 2 && $urandom_range(7) == 0) push_word(rand_word());
      tick();
    end
    change_fetch_width = 1'b0;
    bus_if.receiver_full_n = 1'b1;
    drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
